fifo_fwft: RTL
==============

FIFO_FWFT -- requirements
Module: fifo_fwft

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (1..64).
REQ-002 SHALL have parameter DEPTH, default 256, number of storage words; power of two, minimum 4.
REQ-003 SHALL have parameter FWFT, default 0: 0 = standard read mode, 1 = first-word-fall-through mode.
REQ-004 SHALL define derived constant AW = clog2(DEPTH), and size count and level ports AW+1 bits.
REQ-005 i_clk  in  1  single clock; all logic on rising edge.
REQ-006 i_rst  in  1  synchronous, active-high reset.
REQ-007 i_wr_dv  in  1  write request.
REQ-008 i_wr_data  in  WIDTH  write word.
REQ-009 o_full  out  1  count == DEPTH.
REQ-010 i_af_level  in  AW+1  almost-full threshold.
REQ-011 o_af_flag  out  1  almost-full.
REQ-012 i_rd_en  in  1  read request (standard mode) or pop (FWFT mode).
REQ-013 o_rd_dv  out  1  o_rd_data valid.
REQ-014 o_rd_data  out  WIDTH  read word.
REQ-015 o_empty  out  1  count == 0.
REQ-016 i_ae_level  in  AW+1  almost-empty threshold.
REQ-017 o_ae_flag  out  1  almost-empty.
REQ-018 o_count  out  AW+1  stored-word count.
REQ-019 o_ovf / o_udf  out  1 each  sticky overflow / underflow flags (REQ-034).

Function
REQ-020 Write SHALL be accepted iff i_wr_dv and count < DEPTH; a rejected write SHALL leave storage, pointers and count unchanged.
REQ-021 Standard mode: read SHALL be accepted iff i_rd_en and count != 0; o_rd_dv SHALL pulse exactly one cycle after each accepted read, with o_rd_data holding the head word in that cycle.
REQ-022 FWFT mode: o_rd_dv SHALL be high whenever a head word is presented; a pop SHALL be accepted iff i_rd_en and o_rd_dv; the next word, if any, SHALL be presented in the following cycle with no bubble.
REQ-023 FWFT mode: a word written into an empty FIFO SHALL raise o_rd_dv exactly 2 cycles after its write edge.
REQ-024 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-025 count SHALL be accepted writes minus accepted reads; a simultaneous accepted read and write SHALL leave count unchanged.
REQ-026 A simultaneous read and write at count == DEPTH SHALL accept the read only; at count == 0, the write only.
REQ-027 o_full, o_empty and o_count SHALL be derived from the registered count (no combinational path from i_wr_dv or i_rd_en).
REQ-028 o_af_flag SHALL equal (count >= i_af_level); o_ae_flag SHALL equal (count <= i_ae_level).
REQ-029 o_rd_data SHALL hold its last value while o_rd_dv is low.

Reset
REQ-030 On i_rst high at a clock edge, pointers, count, prefetch state, o_rd_dv, o_ovf and o_udf SHALL clear to 0, and o_rd_data SHALL clear to 0.
REQ-031 After reset, o_empty = 1, o_full = 0, and o_ae_flag = 1 whenever i_ae_level >= 0.
REQ-032 Reset asserted mid-operation SHALL discard all stored words and any in-flight read within the same edge; requests in the reset cycle SHALL be ignored.
REQ-033 Storage array contents SHALL NOT be reset.

Configuration
REQ-034 With macro FIFO_ERR_FLAGS_EN defined: o_ovf SHALL set on any rejected write and o_udf on any rejected read (standard mode) or pop (FWFT mode), and both SHALL stay set until i_rst. Without the macro, both ports SHALL be tied to 0 and no flag logic SHALL be generated.

Structure
REQ-035 The clog2 function and the FWFT mode encoding constants SHALL live in shared package fifo_pkg.
REQ-036 Storage SHALL be a separate sub-module, fifo_mem: simple dual-port, with a synchronous 1-cycle read and a write-first-free address space. The FIFO SHALL never read an address in the same cycle it is written.

Verification
REQ-037 Use WIDTH=8, DEPTH=16, FWFT=0. Write 0x00..0x0F on 16 cycles, then read 16 -> o_full=1 after the 16th write; reads return 0x00..0x0F, each with o_rd_dv one cycle after i_rd_en; o_empty=1 at the end.
REQ-038 Set FWFT=1. Write 0xA5 to an empty FIFO -> o_rd_dv=1 with o_rd_data=0xA5 two cycles later. Write 3 words, then pop continuously -> one word per cycle, no bubble.
REQ-039 Hold count at 8; drive simultaneous read and write for 20 cycles with pointers wrapping -> o_count stays 8 and data order is preserved.
REQ-040 Set i_af_level=12 and i_ae_level=3. Fill 0 -> 16 -> o_ae_flag falls at count 4 and o_af_flag rises at count 12. Then write while full with a simultaneous read -> only the read is accepted.
REQ-041 With FIFO_ERR_FLAGS_EN defined: write at count 16 -> o_ovf=1 sticky; read at count 0 -> o_udf=1; i_rst -> both 0. Without the macro -> both stay 0.
REQ-042 Assert i_rst for one cycle with count=5 and a read in flight -> the next cycle shows o_count=0, o_rd_dv=0 and o_empty=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO family: the read-mode encoding and a
// width helper used to size pointers and counters.
package fifo_pkg;

  localparam int FWFT_STD          = 0;
  localparam int FWFT_FALL_THROUGH = 1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_fwft_if.sv
// Write/read/status bundle of fifo_fwft. The master side is the FIFO user and
// the slave side is the FIFO itself.
interface fifo_fwft_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 256
);
   import fifo_pkg::*;

   localparam int AW = clog2(DEPTH);

   logic             i_wr_dv;
   logic [WIDTH-1:0] i_wr_data;
   logic             o_full;
   logic [AW:0]      i_af_level;
   logic             o_af_flag;
   logic             i_rd_en;
   logic             o_rd_dv;
   logic [WIDTH-1:0] o_rd_data;
   logic             o_empty;
   logic [AW:0]      i_ae_level;
   logic             o_ae_flag;
   logic [AW:0]      o_count;
   logic             o_ovf;
   logic             o_udf;

   modport master (
      output i_wr_dv, i_wr_data, i_af_level, i_rd_en, i_ae_level,
      input  o_full, o_af_flag, o_rd_dv, o_rd_data, o_empty, o_ae_flag,
             o_count, o_ovf, o_udf
   );

   modport slave (
      input  i_wr_dv, i_wr_data, i_af_level, i_rd_en, i_ae_level,
      output o_full, o_af_flag, o_rd_dv, o_rd_data, o_empty, o_ae_flag,
             o_count, o_ovf, o_udf
   );

endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port storage with a registered 1-cycle read port. The caller
// guarantees a location is never read in the cycle it is written.
module fifo_mem import fifo_pkg::*; #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 256
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_wr_en,
   input  logic [clog2(DEPTH)-1:0]  i_wr_addr,
   input  logic [WIDTH-1:0]         i_wr_data,
   input  logic                     i_rd_en,
   input  logic [clog2(DEPTH)-1:0]  i_rd_addr,
   output logic [WIDTH-1:0]         o_rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: the array has no reset so it maps onto block RAM; only the read
   // register below is cleared. Sequential state always uses <= so every
   // flop samples pre-edge values regardless of block ordering.
   always_ff @(posedge i_clk) begin
      if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst)        o_rd_data <= '0;
      else if (i_rd_en) o_rd_data <= mem[i_rd_addr];
   end

endmodule

// File: rtl/fifo_fwft.sv
// Synchronous FIFO with standard or first-word-fall-through read port.
// Define FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags.
module fifo_fwft import fifo_pkg::*; #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 256,
   parameter int FWFT  = FWFT_STD
) (
   input  logic       i_clk,
   input  logic       i_rst,
   fifo_fwft_if.slave bus
);

   localparam int          AW        = clog2(DEPTH);
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             wr_acc;
   logic             rd_acc;
   logic             fetch;
   logic [WIDTH-1:0] mem_rd_data;

   assign wr_acc = bus.i_wr_dv && (count < DEPTH_CNT);

   // rd_ptr follows RAM fetches; count follows reads/pops seen by the user.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (fetch)  rd_ptr <= rd_ptr + 1'b1;
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_wr_en   (wr_acc),
      .i_wr_addr (wr_ptr),
      .i_wr_data (bus.i_wr_data),
      .i_rd_en   (fetch),
      .i_rd_addr (rd_ptr),
      .o_rd_data (mem_rd_data)
   );

   generate
      if (FWFT == FWFT_FALL_THROUGH) begin : g_fwft
         // Two-stage prefetch: the RAM read register, then the presented word.
         logic             s1_valid;
         logic             out_valid;
         logic             s1_take;
         logic [WIDTH-1:0] out_data;
         logic [AW:0]      ram_words;

         assign rd_acc    = bus.i_rd_en && out_valid;
         assign s1_take   = s1_valid && (!out_valid || rd_acc);
         assign ram_words = count - {{AW{1'b0}}, s1_valid} - {{AW{1'b0}}, out_valid};
         assign fetch     = (ram_words != '0) && (!s1_valid || s1_take);

         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               s1_valid  <= 1'b0;
               out_valid <= 1'b0;
               out_data  <= '0;
            end else begin
               if (fetch)        s1_valid <= 1'b1;
               else if (s1_take) s1_valid <= 1'b0;

               if (s1_take) begin
                  out_valid <= 1'b1;
                  out_data  <= mem_rd_data;
               end else if (rd_acc) begin
                  out_valid <= 1'b0;
               end
            end
         end

         assign bus.o_rd_dv   = out_valid;
         assign bus.o_rd_data = out_data;
      end else begin : g_std
         logic rd_dv;

         assign rd_acc = bus.i_rd_en && (count != '0);
         assign fetch  = rd_acc;

         always_ff @(posedge i_clk) begin
            if (i_rst) rd_dv <= 1'b0;
            else       rd_dv <= rd_acc;
         end

         assign bus.o_rd_dv   = rd_dv;
         assign bus.o_rd_data = mem_rd_data;
      end
   endgenerate

`ifdef FIFO_ERR_FLAGS_EN
   logic ovf;
   logic udf;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ovf <= 1'b0;
         udf <= 1'b0;
      end else begin
         if (bus.i_wr_dv && !wr_acc) ovf <= 1'b1;
         if (bus.i_rd_en && !rd_acc) udf <= 1'b1;
      end
   end

   assign bus.o_ovf = ovf;
   assign bus.o_udf = udf;
`else
   assign bus.o_ovf = 1'b0;
   assign bus.o_udf = 1'b0;
`endif

   assign bus.o_count   = count;
   assign bus.o_full    = (count == DEPTH_CNT);
   assign bus.o_empty   = (count == '0);
   assign bus.o_af_flag = (count >= bus.i_af_level);
   assign bus.o_ae_flag = (count <= bus.i_ae_level);

endmodule
